credit_tx: RTL and testbench
============================

Name: credit_tx

Overview:
- Transmit end of a credit-flow link whose far end is a receive fifo of depth 2**FIFO_DEPTH_W.
- Accepts words on a valid/ready input stream and forwards them over a link that has no backpressure wire.
- Never sends more words than the remote fifo has free slots; the remote side returns one credit pulse per word it pops.
- Sits between a local producer and the link driving a remote fifo instance.

Parameters:
FIFO_DEPTH_W, 5, log2 of remote fifo depth; CREDITS_MAX = 2**FIFO_DEPTH_W (1 when FIFO_DEPTH_W = 0)
DATA_W, 8, payload width

Ports:
clk  in  1  clock, all state on rising edge
nrst  in  1  asynchronous active-low reset
link_up  in  1  remote receiver ready; level signal, already synchronous to clk
a_data  in  DATA_W  upstream payload
a_valid  in  1  upstream word present
a_ready  out  1  block accepts a_data this cycle
tx_data  out  DATA_W  link payload, registered
tx_valid  out  1  link strobe, registered, one cycle per word
credit_in  in  1  one-cycle pulse; remote fifo popped one word
credits  out  FIFO_DEPTH_W+1  current credit count
err_overflow  out  1  sticky: credit returned beyond CREDITS_MAX

Behaviour:
- Reset (nrst low, async):
  - state = DOWN, credits = 0, tx_valid = 0, tx_data = 0, err_overflow = 0.
  - a_ready = 0 while in reset.
- States:
  - DOWN:
    - a_ready = 0.
    - credit_in is ignored.
    - When link_up = 1 at a clock edge: go to RUN and load credits = CREDITS_MAX.
  - RUN:
    - Normal operation, as below.
    - When link_up = 0 at a clock edge: go to DOWN and clear credits to 0.
    - tx_valid drops next cycle. Any word accepted in that same cycle is still sent.
- a_ready is combinational: (state == RUN) && (credits != 0) && link_up.
  - Depends only on registered credits, not on credit_in in the same cycle.
- Send: fire = a_valid & a_ready.
  - Next cycle: tx_valid = 1, tx_data = a_data.
  - Otherwise: tx_valid = 0 and tx_data holds its last value.
  - Latency is exactly 1 cycle; full throughput of 1 word per cycle while credits last.
- Credit arithmetic in RUN: credits_next = credits - fire + credit_in, width FIFO_DEPTH_W+1, unsigned.
  - fire and credit_in in the same cycle: credits unchanged.
  - credits = 0 and credit_in: a_ready stays 0 that cycle; credits = 1 next cycle.
  - credits = CREDITS_MAX, credit_in and no fire: credits stay CREDITS_MAX (saturate) and err_overflow sets to 1.
  - err_overflow clears only on reset.
  - credits can never underflow, because fire requires credits != 0.
- Reset mid-burst: tx_valid drops immediately (async). No partial words exist (single-beat transfers).
- Invariant: credits + in-flight words + remote occupancy = CREDITS_MAX. The bench checks this against a fifo model.

Decomposition:
- Shared package: typedef enum {DOWN, RUN} link_state_t; the CREDITS_MAX function of FIFO_DEPTH_W; credit counter width helper.
  - The fifo and credit_tx both use the width helper.
- One sub-module, credit_counter: up/down saturating counter with load, clear and overflow flag.
  - Reusable later for a credit_rx return path.
- Everything else stays inline.

Test Plan:
- Reset then link_up = 1, FIFO_DEPTH_W = 2 -> credits = 4 after one edge; a_ready = 1.
- 4 back-to-back words 0x11..0x14, no credit_in -> tx_valid = 1 four consecutive cycles one cycle later with the same data; credits 4→0; a_ready = 0 with a fifth word pending.
- At credits = 0, pulse credit_in once -> credits = 1 next cycle; pending fifth word 0x15 sent on the following edge.
- Steady stream with credit_in asserted every cycle alongside fire -> credits constant; 1 word/cycle sustained for 20 words, data order preserved.
- Drop link_up during a burst -> DOWN next edge, credits = 0, a_ready = 0, no further tx_valid; reassert link_up -> credits = 4.
- At credits = 4, idle, pulse credit_in -> credits remain 4, err_overflow = 1 and remains 1 until nrst is pulsed low; an async nrst pulse mid-cycle clears tx_valid without a clock edge.

Source files
------------

// File: rtl/credit_tx_pkg.sv
// Shared types and sizing helpers for the credit link (transmit side and remote fifo).
package credit_tx_pkg;

  typedef enum logic {
    DOWN = 1'b0,
    RUN  = 1'b1
  } link_state_t;

  // A depth-0 exponent still means a one-entry remote fifo.
  function automatic int credits_max(input int depth_w);
    return 1 << depth_w;
  endfunction

  // One extra bit so a completely empty remote fifo can be represented.
  function automatic int credit_w(input int depth_w);
    return depth_w + 1;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter with load, clear, saturation at MAX and a sticky overflow flag.
// Clear beats load; a same-cycle inc+dec leaves the count unchanged.
module credit_counter #(
  parameter int W   = 6,
  parameter int MAX = 32
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_overflow
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_count;
  logic         r_ovf;
  logic [W-1:0] w_next;
  logic         w_sat;

  always_comb begin
    w_sat  = i_inc && !i_dec && (r_count == MAX_V);
    w_next = r_count - W'(i_dec) + W'(i_inc);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= MAX_V;
    end else if (w_sat) begin
      r_ovf   <= 1'b1;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_count    = r_count;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/credit_tx.sv
// Transmit end of a credit link: forwards words one cycle after acceptance and
// never sends more than the remote fifo can hold; credits refill on link-up.
module credit_tx
  import credit_tx_pkg::*;
#(
  parameter int FIFO_DEPTH_W = 5,
  parameter int DATA_W       = 8
) (
  input  logic                                 clk,
  input  logic                                 nrst,
  input  logic                                 link_up,
  input  logic [DATA_W-1:0]                    a_data,
  input  logic                                 a_valid,
  output logic                                 a_ready,
  output logic [DATA_W-1:0]                    tx_data,
  output logic                                 tx_valid,
  input  logic                                 credit_in,
  output logic [credit_w(FIFO_DEPTH_W)-1:0]    credits,
  output logic                                 err_overflow
);

  localparam int CW = credit_w(FIFO_DEPTH_W);

  link_state_t       r_state;
  link_state_t       w_state_next;
  logic              w_fire;
  logic              w_load;
  logic              w_clear;
  logic              w_inc;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic [CW-1:0]     w_credits;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= DOWN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    unique case (r_state)
      DOWN: begin
        if (link_up) begin
          w_state_next = RUN;
          w_load       = 1'b1;
        end
      end
      RUN: begin
        if (!link_up) begin
          w_state_next = DOWN;
          w_clear      = 1'b1;
        end
      end
      default: w_state_next = DOWN;
    endcase
  end

  // Ready looks only at registered credits so a returning credit is usable next cycle.
  assign a_ready = (r_state == RUN) && (w_credits != '0) && link_up;
  assign w_fire  = a_valid && a_ready;
  assign w_inc   = credit_in && (r_state == RUN);

  credit_counter #(
    .W   (CW),
    .MAX (credits_max(FIFO_DEPTH_W))
  ) u_credit_counter (
    .clk        (clk),
    .nrst       (nrst),
    .i_load     (w_load),
    .i_clear    (w_clear),
    .i_inc      (w_inc),
    .i_dec      (w_fire),
    .o_count    (w_credits),
    .o_overflow (err_overflow)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_valid <= w_fire;
      if (w_fire) r_tx_data <= a_data;
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign credits  = w_credits;

endmodule

// File: tb/tb_credit_tx.sv
// Bench for credit_tx (FIFO_DEPTH_W=2): directed scenarios plus a random run against a remote fifo model.
module tb_credit_tx;

  localparam int DW   = 2;
  localparam int CMAX = 4;

  logic       clk;
  logic       nrst;
  logic       link_up;
  logic [7:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       credit_in;
  logic [2:0] credits;
  logic       err_overflow;

  credit_tx #(.FIFO_DEPTH_W(DW), .DATA_W(8)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .link_up      (link_up),
    .a_data       (a_data),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .credit_in    (credit_in),
    .credits      (credits),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: link up/down flag, credit count as a plain integer.
  bit         m_up;
  int         m_credits;
  bit         m_err;
  bit         m_tx_valid;
  logic [7:0] m_tx_data;
  bit         exp_ready;
  logic       obs_ready;

  task automatic model_reset();
    m_up = 0; m_credits = 0; m_err = 0; m_tx_valid = 0; m_tx_data = 8'h00;
  endtask

  // Drive one cycle of inputs from a negedge, sample ready, step the model, return at next negedge.
  task automatic cycle(input bit av, input logic [7:0] ad, input bit ci, input bit lu);
    bit fire;
    int n;
    a_valid = av; a_data = ad; credit_in = ci; link_up = lu;
    #1;
    exp_ready = m_up && (m_credits != 0) && lu;
    obs_ready = a_ready;
    fire = av && exp_ready;
    @(posedge clk);
    m_tx_valid = fire;
    if (fire) m_tx_data = ad;
    if (!m_up) begin
      if (lu) begin m_up = 1; m_credits = CMAX; end
    end else if (!lu) begin
      m_up = 0; m_credits = 0;
    end else begin
      n = m_credits - int'(fire) + int'(ci);
      if (n > CMAX) begin n = CMAX; m_err = 1; end
      m_credits = n;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b1; link_up = 1'b1; a_valid = 1'b1; a_data = 8'hAA; credit_in = 1'b1;
    #1 nrst = 1'b0;
    @(negedge clk);
    n_cmp++; if (credits !== 3'd0) begin n_bad++; $display("FAIL reset_credits got=%0d exp=0", credits); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    n_cmp++; if (err_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%0b exp=0", err_overflow); end
    n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL reset_a_ready got=%0b exp=0", a_ready); end
    link_up = 1'b0; a_valid = 1'b0; credit_in = 1'b0;
    nrst = 1'b1;
    model_reset();
  endtask

  task automatic test_link_up();
    cycle(0, 8'h00, 0, 1);
    n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL up_ready_down got=%0b exp=0", obs_ready); end
    n_cmp++; if (credits !== 3'd4) begin n_bad++; $display("FAIL up_credits got=%0d exp=4", credits); end
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL up_a_ready got=%0b exp=1", a_ready); end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 8'h11 + 8'(i), 0, 1);
      n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL burst_ready i=%0d got=%0b exp=1", i, obs_ready); end
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h11 + 8'(i)) begin
        n_bad++; $display("FAIL burst_tx i=%0d got=%0b/%h exp=1/%h", i, tx_valid, tx_data, 8'h11 + 8'(i)); end
      n_cmp++; if (credits !== 3'(m_credits)) begin n_bad++; $display("FAIL burst_credits i=%0d got=%0d exp=%0d", i, credits, m_credits); end
    end
    cycle(1, 8'h15, 0, 1);
    n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL burst_stall_ready got=%0b exp=0", obs_ready); end
    n_cmp++; if (tx_valid !== 1'b0 || credits !== 3'd0) begin
      n_bad++; $display("FAIL burst_stall got=v%0b/c%0d exp=v0/c0", tx_valid, credits); end
  endtask

  task automatic test_credit_return();
    cycle(1, 8'h15, 1, 1);
    n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL ret_ready_same got=%0b exp=0", obs_ready); end
    n_cmp++; if (credits !== 3'd1) begin n_bad++; $display("FAIL ret_credits got=%0d exp=1", credits); end
    cycle(1, 8'h15, 0, 1);
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL ret_ready_next got=%0b exp=1", obs_ready); end
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h15) begin
      n_bad++; $display("FAIL ret_tx got=%0b/%h exp=1/15", tx_valid, tx_data); end
    n_cmp++; if (credits !== 3'd0) begin n_bad++; $display("FAIL ret_credits_after got=%0d exp=0", credits); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 1, 1);
    n_cmp++; if (credits !== 3'd2) begin n_bad++; $display("FAIL b2b_prefill got=%0d exp=2", credits); end
    for (int i = 0; i < 20; i++) begin
      w = 8'($urandom);
      cycle(1, w, 1, 1);
      n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready i=%0d got=%0b exp=1", i, obs_ready); end
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== w) begin
        n_bad++; $display("FAIL b2b_tx i=%0d got=%0b/%h exp=1/%h", i, tx_valid, tx_data, w); end
      n_cmp++; if (credits !== 3'd2) begin n_bad++; $display("FAIL b2b_credits i=%0d got=%0d exp=2", i, credits); end
    end
  endtask

  task automatic test_link_drop();
    cycle(1, 8'h31, 0, 1);
    cycle(1, 8'h32, 0, 1);
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h32) begin
      n_bad++; $display("FAIL drop_pre_tx got=%0b/%h exp=1/32", tx_valid, tx_data); end
    cycle(1, 8'h33, 0, 0);
    n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL drop_ready got=%0b exp=0", obs_ready); end
    n_cmp++; if (credits !== 3'd0 || tx_valid !== 1'b0) begin
      n_bad++; $display("FAIL drop_state got=c%0d/v%0b exp=c0/v0", credits, tx_valid); end
    cycle(1, 8'h34, 1, 0);
    n_cmp++; if (obs_ready !== 1'b0 || tx_valid !== 1'b0 || credits !== 3'd0) begin
      n_bad++; $display("FAIL drop_idle got=r%0b/v%0b/c%0d exp=r0/v0/c0", obs_ready, tx_valid, credits); end
    cycle(0, 8'h00, 0, 1);
    n_cmp++; if (credits !== 3'd4) begin n_bad++; $display("FAIL drop_reup got=%0d exp=4", credits); end
  endtask

  task automatic test_random();
    logic [7:0] rq[$];
    bit         pop;
    bit         pv;
    logic [7:0] pd;
    for (int i = 0; i < 300; i++) begin
      pop = (rq.size() > 0) && ($urandom_range(0, 2) == 0);
      pv = tx_valid; pd = tx_data;
      cycle($urandom_range(0, 3) != 0, 8'($urandom), pop, 1);
      if (pop) void'(rq.pop_front());
      if (pv) rq.push_back(pd);
      n_cmp++; if (obs_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready i=%0d got=%0b exp=%0b", i, obs_ready, exp_ready); end
      n_cmp++; if (tx_valid !== m_tx_valid || (m_tx_valid && tx_data !== m_tx_data)) begin
        n_bad++; $display("FAIL rnd_tx i=%0d got=%0b/%h exp=%0b/%h", i, tx_valid, tx_data, m_tx_valid, m_tx_data); end
      n_cmp++; if (credits !== 3'(m_credits)) begin n_bad++; $display("FAIL rnd_credits i=%0d got=%0d exp=%0d", i, credits, m_credits); end
      n_cmp++; if (int'(credits) + int'(tx_valid) + rq.size() != CMAX) begin
        n_bad++; $display("FAIL rnd_invariant i=%0d got=%0d exp=%0d", i, int'(credits) + int'(tx_valid) + rq.size(), CMAX); end
      n_cmp++; if (err_overflow !== 1'b0) begin n_bad++; $display("FAIL rnd_err i=%0d got=%0b exp=0", i, err_overflow); end
    end
  endtask

  task automatic test_overflow();
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 1, 1);
    n_cmp++; if (credits !== 3'd4) begin n_bad++; $display("FAIL ovf_credits got=%0d exp=4", credits); end
    n_cmp++; if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%0b exp=1", err_overflow); end
    for (int i = 0; i < 3; i++) begin
      cycle(i == 1, 8'h40, i == 1, 1);
      n_cmp++; if (err_overflow !== 1'b1 || credits !== 3'(m_credits)) begin
        n_bad++; $display("FAIL ovf_sticky i=%0d got=e%0b/c%0d exp=e1/c%0d", i, err_overflow, credits, m_credits); end
    end
    cycle(1, 8'hA5, 0, 1);
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      n_bad++; $display("FAIL ovf_pre_rst_tx got=%0b/%h exp=1/a5", tx_valid, tx_data); end
    #2 nrst = 1'b0;
    #1;
    n_cmp++; if (tx_valid !== 1'b0 || credits !== 3'd0 || err_overflow !== 1'b0 || a_ready !== 1'b0) begin
      n_bad++; $display("FAIL async_rst got=v%0b/c%0d/e%0b/r%0b exp=v0/c0/e0/r0", tx_valid, credits, err_overflow, a_ready); end
    #1 nrst = 1'b1;
    model_reset();
    @(negedge clk);
    cycle(0, 8'h00, 0, 1);
    n_cmp++; if (credits !== 3'd4 || err_overflow !== 1'b0) begin
      n_bad++; $display("FAIL post_rst got=c%0d/e%0b exp=c4/e0", credits, err_overflow); end
  endtask

  initial begin
    test_reset();
    test_link_up();
    test_burst();
    test_credit_return();
    test_back_to_back();
    test_link_drop();
    test_random();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
